// File: rtl/dly_sel_sequencer_if.sv
// Command handshake bundle for dly_sel_sequencer.
// master = fabric delay-control logic issuing commands; slave = the sequencer.
interface dly_sel_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int TAP_W  = 6
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [1:0]        CMD_OP;
    logic [TAP_W-1:0]  CMD_STEPS;
    logic              CMD_DONE;
    logic              CMD_SAT;
    logic              CMD_ERR;

    modport master (
        output CMD_VALID, CMD_ADDR, CMD_OP, CMD_STEPS,
        input  CMD_READY, CMD_DONE, CMD_SAT, CMD_ERR
    );

    modport slave (
        input  CMD_VALID, CMD_ADDR, CMD_OP, CMD_STEPS,
        output CMD_READY, CMD_DONE, CMD_SAT, CMD_ERR
    );
endinterface

// File: rtl/dly_sel_sequencer.sv
// Delay select sequencer: accepts LOAD/INC/DEC commands for one of NUM_CH
// delay elements, emits spaced single-cycle ADJ pulses, keeps a shadow tap
// counter per channel for saturation and readback.
// Optional build macro DLY_SEL_ADDR_CHECK_EN: out-of-range addresses complete
// immediately with CMD_ERR instead of being sequenced silently.
// All outputs are flops; the next-cycle output value is decoded from the
// next state so that a pulse appears the cycle after the deciding edge.
module dly_sel_sequencer #(
    parameter int NUM_CH       = 20,
    parameter int ADDR_W       = 5,
    parameter int TAP_W        = 6,
    parameter int GAP_CYCLES   = 2,
    parameter int DLY_TAP_INIT = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    dly_sel_sequencer_if.slave    cmd,
    output logic [3*NUM_CH-1:0]   DLY_CNTRL,
    input  logic [ADDR_W-1:0]     RD_ADDR,
    output logic [TAP_W-1:0]      RD_TAP
);

    localparam logic [1:0]       OP_NOP   = 2'b00;
    localparam logic [1:0]       OP_LOAD  = 2'b01;
    localparam logic [1:0]       OP_INC   = 2'b10;
    localparam logic [TAP_W-1:0] TAP_MAX  = {TAP_W{1'b1}};
    localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(DLY_TAP_INIT);
    localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          op_q, op_d;
    logic [TAP_W-1:0]    steps_q, steps_d;
    logic [3:0]          gap_q, gap_d;
    logic                sat_flag_q, sat_flag_d;
    logic                err_flag_q, err_flag_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                cmd_done_q, cmd_done_d;
    logic                cmd_sat_q, cmd_sat_d;
    logic                cmd_err_q, cmd_err_d;
    logic [3*NUM_CH-1:0] dly_cntrl_q, dly_cntrl_d;
    logic [TAP_W-1:0]    rd_tap_q, rd_tap_d;
    logic [TAP_W-1:0]    shadow_q [NUM_CH];
    logic [TAP_W-1:0]    shadow_d [NUM_CH];

    logic                accept;
    logic [ADDR_W-1:0]   addr_sel;
    logic [1:0]          op_sel;
    logic                is_inc;
    logic                in_range;
    logic [TAP_W-1:0]    cur_tap;
    logic                at_limit;
    logic                bad_addr;
    logic                enter_pulse;
    logic                pulse_go;
    logic                load_go;
    logic                drive;
    logic [2:0]          code;

    // Command in flight: the incoming one on the accept edge, else the latched one.
    always_comb begin
        accept   = (state_q == S_IDLE) && cmd_ready_q && cmd.CMD_VALID;
        addr_sel = accept ? cmd.CMD_ADDR : addr_q;
        op_sel   = accept ? cmd.CMD_OP   : op_q;
        is_inc   = (op_sel == OP_INC);
        in_range = ({1'b0, addr_sel} < (ADDR_W+1)'(NUM_CH));
        cur_tap  = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (addr_sel == ADDR_W'(n)) cur_tap = shadow_q[n];
        end
        // Out-of-range channels have no shadow, so they can never saturate.
        at_limit = in_range && (is_inc ? (cur_tap == TAP_MAX) : (cur_tap == '0));
    end

    // Next-state, shadow update and next-cycle output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_sel;
        op_d        = op_sel;
        steps_d     = steps_q;
        gap_d       = gap_q;
        sat_flag_d  = sat_flag_q;
        err_flag_d  = err_flag_q;
        shadow_d    = shadow_q;
        enter_pulse = 1'b0;
        pulse_go    = 1'b0;
        load_go     = 1'b0;
        bad_addr    = 1'b0;
`ifdef DLY_SEL_ADDR_CHECK_EN
        bad_addr    = !in_range;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    steps_d    = (cmd.CMD_STEPS == '0) ? TAP_W'(1) : cmd.CMD_STEPS;
                    sat_flag_d = 1'b0;
                    err_flag_d = 1'b0;
                    if (bad_addr) begin
                        err_flag_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        case (cmd.CMD_OP)
                            OP_NOP:  state_d = S_DONE;
                            OP_LOAD: begin
                                state_d = S_LOAD;
                                load_go = 1'b1;
                            end
                            default: enter_pulse = 1'b1;
                        endcase
                    end
                end
            end
            S_LOAD:  state_d = S_DONE;
            S_PULSE: begin
                if (sat_flag_q) begin
                    state_d = S_DONE;
                end else if (GAP_CYCLES > 0) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else if (steps_q != '0) begin
                    enter_pulse = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (steps_q != '0) enter_pulse = 1'b1;
                    else               state_d     = S_DONE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Saturation is judged against the shadow as it stands before this pulse.
        if (enter_pulse) begin
            state_d = S_PULSE;
            if (at_limit) begin
                sat_flag_d = 1'b1;
            end else begin
                pulse_go = 1'b1;
                steps_d  = steps_d - TAP_W'(1);
            end
        end

        for (int n = 0; n < NUM_CH; n++) begin
            if (addr_sel == ADDR_W'(n)) begin
                if (pulse_go) shadow_d[n] = is_inc ? shadow_q[n] + TAP_W'(1)
                                                   : shadow_q[n] - TAP_W'(1);
                if (load_go)  shadow_d[n] = TAP_INIT;
            end
        end

        code  = 3'b000;
        drive = 1'b0;
        case (state_d)
            S_LOAD: begin
                code  = 3'b100;
                drive = 1'b1;
            end
            S_PULSE: begin
                code  = {2'b01, is_inc};
                drive = pulse_go;
            end
            S_GAP: begin
                code  = {2'b00, is_inc};
                drive = 1'b1;
            end
            default: ;
        endcase

        // Only the addressed channel ever sees a non-zero field.
        dly_cntrl_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (drive && (addr_sel == ADDR_W'(n))) dly_cntrl_d[3*n +: 3] = code;
        end

        cmd_ready_d = (state_d == S_IDLE);
        cmd_done_d  = (state_d == S_DONE);
        cmd_sat_d   = cmd_done_d && sat_flag_d;
`ifdef DLY_SEL_ADDR_CHECK_EN
        cmd_err_d   = cmd_done_d && err_flag_d;
`else
        cmd_err_d   = 1'b0;
`endif

        // Readback sees the registered shadow, i.e. the pre-update value.
        rd_tap_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (RD_ADDR == ADDR_W'(n)) rd_tap_d = shadow_q[n];
        end
    end

    // State, latched command, shadow taps and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            op_q        <= OP_NOP;
            steps_q     <= '0;
            gap_q       <= '0;
            sat_flag_q  <= 1'b0;
            err_flag_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            cmd_sat_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
            dly_cntrl_q <= '0;
            rd_tap_q    <= '0;
            for (int n = 0; n < NUM_CH; n++) shadow_q[n] <= TAP_INIT;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            steps_q     <= steps_d;
            gap_q       <= gap_d;
            sat_flag_q  <= sat_flag_d;
            err_flag_q  <= err_flag_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_done_q  <= cmd_done_d;
            cmd_sat_q   <= cmd_sat_d;
            cmd_err_q   <= cmd_err_d;
            dly_cntrl_q <= dly_cntrl_d;
            rd_tap_q    <= rd_tap_d;
            shadow_q    <= shadow_d;
        end
    end

    assign cmd.CMD_READY = cmd_ready_q;
    assign cmd.CMD_DONE  = cmd_done_q;
    assign cmd.CMD_SAT   = cmd_sat_q;
    assign cmd.CMD_ERR   = cmd_err_q;
    assign DLY_CNTRL     = dly_cntrl_q;
    assign RD_TAP        = rd_tap_q;

endmodule

// File: tb/tb_dly_sel_sequencer.sv
// Bench for dly_sel_sequencer: a tap model expands each command into its
// expected per-cycle output trace, queued at acceptance and compared cycle by
// cycle on the falling edge.
module tb_dly_sel_sequencer;
    localparam int NCH  = 20;
    localparam int AW   = 5;
    localparam int TW   = 6;
    localparam int GAP  = 2;
    localparam int INIT = 0;
    localparam int TMAX = (1 << TW) - 1;
    localparam int W    = 3 * NCH;

    typedef struct {
        logic [W-1:0] dly;
        logic         done;
        logic         sat;
        logic         err;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  DLY_CNTRL;
    logic [AW-1:0] RD_ADDR = '0;
    logic [TW-1:0] RD_TAP;

    dly_sel_sequencer_if #(.ADDR_W(AW), .TAP_W(TW)) cif ();

    dly_sel_sequencer #(
        .NUM_CH(NCH), .ADDR_W(AW), .TAP_W(TW), .GAP_CYCLES(GAP), .DLY_TAP_INIT(INIT)
    ) dut (
        .CLK(CLK), .RST(RST), .cmd(cif), .DLY_CNTRL(DLY_CNTRL),
        .RD_ADDR(RD_ADDR), .RD_TAP(RD_TAP)
    );

    always #5 CLK = ~CLK;

    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_en = 0;
    int   mdl [NCH];
    exp_t expq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fld(input int a, input logic [2:0] c);
        logic [W-1:0] v;
        v = '0;
        v[3*a +: 3] = c;
        return v;
    endfunction

    task automatic push(input logic [W-1:0] d, input logic dn, input logic s, input logic e);
        exp_t x;
        x.dly = d; x.done = dn; x.sat = s; x.err = e;
        expq.push_back(x);
    endtask

    // Expected trace for one command, starting with the cycle after acceptance.
    task automatic model_cmd(input int op, input int addr, input int steps);
        bit ok;
        bit inc;
        bit sat;
        int s;
        ok = (addr < NCH);
`ifdef DLY_SEL_ADDR_CHECK_EN
        if (!ok) begin
            push('0, 1'b1, 1'b0, 1'b1);
            return;
        end
`endif
        if (op == 0) begin
            push('0, 1'b1, 1'b0, 1'b0);
        end else if (op == 1) begin
            push(ok ? fld(addr, 3'b100) : '0, 1'b0, 1'b0, 1'b0);
            if (ok) mdl[addr] = INIT;
            push('0, 1'b1, 1'b0, 1'b0);
        end else begin
            inc = (op == 2);
            s   = (steps == 0) ? 1 : steps;
            sat = 0;
            for (int i = 0; i < s; i++) begin
                if (ok && (inc ? (mdl[addr] == TMAX) : (mdl[addr] == 0))) begin
                    push('0, 1'b0, 1'b0, 1'b0);
                    sat = 1;
                    break;
                end
                push(ok ? fld(addr, {2'b01, inc}) : '0, 1'b0, 1'b0, 1'b0);
                if (ok) mdl[addr] = inc ? mdl[addr] + 1 : mdl[addr] - 1;
                for (int g = 0; g < GAP; g++) push(ok ? fld(addr, {2'b00, inc}) : '0, 1'b0, 1'b0, 1'b0);
            end
            push('0, 1'b1, sat, 1'b0);
        end
    endtask

    // Cycle-by-cycle comparison against the queued trace; idle when empty.
    always @(negedge CLK) begin
        exp_t e;
        if (mon_en) begin
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("dly_cntrl", DLY_CNTRL, e.dly);
                chk("cmd_done", cif.CMD_DONE, e.done);
                chk("busy_ready", cif.CMD_READY, 0);
                if (e.done) begin
                    chk("cmd_sat", cif.CMD_SAT, e.sat);
                    chk("cmd_err", cif.CMD_ERR, e.err);
                end
            end else begin
                chk("idle_dly", DLY_CNTRL, 0);
                chk("idle_done", cif.CMD_DONE, 0);
            end
        end
    end

    task automatic cmd(input int op, input int addr, input int steps, input bit wait_done);
        int t;
        t = 0;
        @(negedge CLK);
        while (cif.CMD_READY !== 1'b1 && t < 300) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 300) chk("ready_timeout", cif.CMD_READY, 1);
        cif.CMD_VALID = 1'b1;
        cif.CMD_OP    = 2'(op);
        cif.CMD_ADDR  = AW'(addr);
        cif.CMD_STEPS = TW'(steps);
        @(posedge CLK);
        #1;
        cif.CMD_VALID = 1'b0;
        cif.CMD_OP    = 2'(~op);
        model_cmd(op, addr, steps);
        if (wait_done) begin
            t = 0;
            while (expq.size() > 0 && t < 1000) begin
                @(negedge CLK);
                t++;
            end
            chk("drain_timeout", 64'(expq.size()), 0);
        end
    endtask

    task automatic rd_chk(input int a, input int exp);
        @(negedge CLK);
        RD_ADDR = AW'(a);
        @(negedge CLK);
        chk($sformatf("rd_tap[%0d]", a), RD_TAP, 64'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        int o;
        cif.CMD_VALID = 1'b0;
        cif.CMD_OP    = 2'b00;
        cif.CMD_ADDR  = '0;
        cif.CMD_STEPS = '0;
        for (int n = 0; n < NCH; n++) mdl[n] = INIT;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_ready", cif.CMD_READY, 0);
        chk("rst_dly", DLY_CNTRL, 0);
        chk("rst_done", cif.CMD_DONE, 0);
        chk("rst_sat", cif.CMD_SAT, 0);
        chk("rst_err", cif.CMD_ERR, 0);
        chk("rst_rdtap", RD_TAP, 0);
        RST = 1'b0;
        mon_en = 1;
        repeat (2) @(negedge CLK);
        chk("post_rst_ready", cif.CMD_READY, 1);
        rd_chk(7, 0);

        // INC 4 steps on channel 3: pulses every 1+GAP cycles, then done
        cmd(2, 3, 4, 1);
        rd_chk(3, 4);

        // Run channel 19 to the top, saturate, then back off
        cmd(2, 19, 63, 1);
        rd_chk(19, 63);
        cmd(2, 19, 5, 1);
        rd_chk(19, 63);
        cmd(3, 19, 3, 1);
        rd_chk(19, 60);
        // Saturation partway: 3 pulses stand, 4th check trips
        cmd(2, 19, 5, 1);
        rd_chk(19, 63);

        // DEC at zero saturates immediately
        cmd(3, 4, 2, 1);
        rd_chk(4, 0);

        // LOAD after INC 10
        cmd(2, 0, 10, 1);
        rd_chk(0, 10);
        cmd(1, 0, 0, 1);
        rd_chk(0, 0);

        // Zero steps behave as one; NOP completes with no activity
        cmd(2, 1, 0, 1);
        rd_chk(1, 1);
        cmd(0, 2, 7, 1);

        // Out-of-range address
        cmd(2, 25, 2, 1);
        rd_chk(25, 0);

        // Reset in the 2nd gap cycle of INC ch5 x6
        cmd(2, 5, 6, 0);
        repeat (3) @(negedge CLK);
        #1;
        RST = 1'b1;
        expq.delete();
        for (int n = 0; n < NCH; n++) mdl[n] = INIT;
        @(negedge CLK);
        chk("midrst_ready", cif.CMD_READY, 0);
        chk("midrst_dly", DLY_CNTRL, 0);
        chk("midrst_done", cif.CMD_DONE, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("midrst_ready_back", cif.CMD_READY, 1);
        rd_chk(5, 0);
        rd_chk(3, 0);

        // Random mix on valid channels
        for (int i = 0; i < 10; i++) begin
            o = $urandom_range(0, 3);
            a = $urandom_range(0, NCH - 1);
            cmd(o, a, $urandom_range(0, 5), 1);
        end
        for (int n = 0; n < NCH; n++) rd_chk(n, mdl[n]);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dly_sel_sequencer.md
Name: dly_sel_sequencer

Overview:
- Parametrised successor to the fixed 20-channel delay select decoder.
- Accepts addressed delay commands over a valid/ready handshake: LOAD, INC, DEC with a step count.
- Sequences one-cycle ADJ pulses to the selected delay element, with a programmable settle gap between pulses.
- Keeps a shadow tap counter per channel for readback and saturation. Sits between fabric delay-control logic and the I/O delay primitives.

Parameters:
- NUM_CH, 20, number of delay channels (1..32).
- ADDR_W, 5, command/read address width; 2^ADDR_W >= NUM_CH.
- TAP_W, 6, tap counter width; max tap = 2^TAP_W-1.
- GAP_CYCLES, 2, idle cycles after each ADJ pulse (0..15; 0 = back-to-back pulses).
- DLY_TAP_INIT, 0, shadow tap value after reset or LOAD.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  high only in IDLE.
- CMD_ADDR  in  ADDR_W  target channel.
- CMD_OP  in  2  00 NOP, 01 LOAD, 10 INC, 11 DEC.
- CMD_STEPS  in  TAP_W  number of INC/DEC steps; 0 treated as 1.
- DLY_CNTRL  out  3*NUM_CH  per channel {LOAD,ADJ,INCDEC}; channel n at bits [3n+2:3n].
- CMD_DONE  out  1  one-cycle completion pulse.
- CMD_SAT  out  1  valid with CMD_DONE; command stopped at a tap limit.
- CMD_ERR  out  1  valid with CMD_DONE; address out of range (see optional feature).
- RD_ADDR  in  ADDR_W  readback channel.
- RD_TAP  out  TAP_W  shadow tap of RD_ADDR; 1-cycle latency.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: CMD_READY=0 while RST is high, 1 in the first IDLE cycle after it. DLY_CNTRL=0, CMD_DONE=0, CMD_SAT=0, CMD_ERR=0, RD_TAP=0. All shadow taps = DLY_TAP_INIT. FSM = IDLE.
- RST mid-command aborts at the next edge. No further pulses, no CMD_DONE.
- All outputs are registered. Channels not being addressed always drive 3'b000.
- FSM states: IDLE, LOAD, PULSE, GAP, DONE.
- IDLE:
  - Accept when CMD_VALID && CMD_READY.
  - NOP -> DONE.
  - LOAD -> LOAD.
  - INC/DEC -> PULSE. Step counter = max(CMD_STEPS,1).
  - Address, op and steps are latched at acceptance. Inputs are ignored while not READY.
- LOAD (1 cycle): selected channel drives 3'b100, shadow <= DLY_TAP_INIT, then -> DONE.
- PULSE (1 cycle):
  - Check before the pulse: INC with shadow == 2^TAP_W-1, or DEC with shadow == 0 -> no pulse, set sat flag, -> DONE.
  - Otherwise drive {0,1,INCDEC} (INCDEC=1 for INC), shadow +/- 1, decrement step counter.
  - Next state: -> GAP if GAP_CYCLES>0. Otherwise -> PULSE if steps remain, else -> DONE.
- GAP (GAP_CYCLES cycles): selected channel drives {0,0,INCDEC} (direction held, ADJ low). Then -> PULSE if steps remain, else -> DONE.
- DONE (1 cycle): CMD_DONE=1 with CMD_SAT/CMD_ERR; DLY_CNTRL=0; -> IDLE.
- Latency: command accepted at edge k, first pulse visible in cycle k+1. Pulse spacing is 1+GAP_CYCLES cycles. CMD_DONE follows the last gap. CMD_READY is high again the cycle after CMD_DONE.
- Unsaturated INC/DEC of S steps: CMD_DONE is S*(1+GAP_CYCLES)+1 cycles after acceptance.
- Saturation partway through a command: earlier pulses stand and the shadow stays at the limit.
- Readback: RD_TAP <= shadow[RD_ADDR] every cycle. RD_ADDR >= NUM_CH returns 0. Reading the channel being updated on the same edge returns the pre-update value.

Optional Feature:
- Macro: DLY_SEL_ADDR_CHECK_EN.
- Defined: CMD_ADDR >= NUM_CH is accepted, no DLY_CNTRL activity and no shadow change, then -> DONE with CMD_ERR=1.
- Not defined: CMD_ERR is tied 0. Out-of-range commands are accepted, sequenced with all DLY_CNTRL bits 0 and no shadow change, and complete with normal timing.

Test Plan:
- Reset, then RD_ADDR=7 -> RD_TAP=0; CMD_READY=1; DLY_CNTRL all 0.
- INC addr 3, steps 4, GAP=2 -> DLY_CNTRL[11:9]=3'b011 in cycles k+1, k+4, k+7, k+10. CMD_DONE at k+13 with CMD_SAT=0. RD_TAP(3)=4. All other channels 0.
- INC addr 19 to 63, then INC steps 5 -> no pulse. CMD_DONE at k+2 with CMD_SAT=1. Tap stays 63. Then DEC steps 3 -> tap 60 and DLY_CNTRL[59:57]=3'b010 pulses.
- LOAD addr 0 after INC 10 -> DLY_CNTRL[2:0]=3'b100 for one cycle; RD_TAP(0)=0; CMD_DONE with SAT=0.
- Assert RST at the 2nd GAP cycle of INC addr 5 steps 6 -> next cycle all outputs 0, no CMD_DONE, RD_TAP(5)=0, CMD_READY=1 after RST is released.
- With DLY_SEL_ADDR_CHECK_EN: INC addr 25 -> CMD_DONE with CMD_ERR=1, DLY_CNTRL stays 0. Without the macro: CMD_ERR=0.
